// File: rtl/beacon_tx.sv
// IR beacon transmitter: square-wave carrier at one of three selectable
// frequencies, sent as bursts of N periods, optionally repeated with silent gaps.
module beacon_tx #(
  parameter int HALF1   = 50000,
  parameter int HALF2   = 25000,
  parameter int HALF3   = 16667,
  parameter int GAP_CYC = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic [7:0] burst_len,
  input  logic       repeat_en,
  input  logic       stop,
  output logic       ir_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] cur_sel
);

  typedef enum logic [1:0] {IDLE, MARK, GAP} state_t;

  localparam logic [16:0] H1_LAST  = 17'(HALF1 - 1);
  localparam logic [16:0] H2_LAST  = 17'(HALF2 - 1);
  localparam logic [16:0] H3_LAST  = 17'(HALF3 - 1);
  localparam logic [23:0] GAP_LAST = 24'(GAP_CYC - 1);

  state_t      state_reg, state_next;
  logic [16:0] half_reg, half_next;
  logic [8:0]  period_reg, period_next;
  logic [23:0] gap_reg, gap_next;
  logic [1:0]  sel_reg, sel_next;
  logic [7:0]  len_reg, len_next;
  logic        rep_reg, rep_next;
  logic        ir_reg, ir_next;
  logic        done_reg, done_next;
  logic [16:0] half_last;
  logic        go_idle;

  // burst_len of 0 encodes a full 256-period burst
  function automatic logic [8:0] load_len(input logic [7:0] l);
    return (l == 8'd0) ? 9'd256 : {1'b0, l};
  endfunction

  always_comb begin
    case (sel_reg)
      2'b01:   half_last = H1_LAST;
      2'b10:   half_last = H2_LAST;
      2'b11:   half_last = H3_LAST;
      default: half_last = 17'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      half_reg   <= '0;
      period_reg <= '0;
      gap_reg    <= '0;
      sel_reg    <= '0;
      len_reg    <= '0;
      rep_reg    <= 1'b0;
      ir_reg     <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      half_reg   <= half_next;
      period_reg <= period_next;
      gap_reg    <= gap_next;
      sel_reg    <= sel_next;
      len_reg    <= len_next;
      rep_reg    <= rep_next;
      ir_reg     <= ir_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    half_next   = half_reg;
    period_next = period_reg;
    gap_next    = gap_reg;
    sel_next    = sel_reg;
    len_next    = len_reg;
    rep_next    = rep_reg;
    ir_next     = ir_reg;
    done_next   = 1'b0;
    go_idle     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !stop && (sel != 2'b00)) begin
          state_next  = MARK;
          sel_next    = sel;
          len_next    = burst_len;
          rep_next    = repeat_en;
          ir_next     = 1'b1;
          half_next   = '0;
          period_next = load_len(burst_len);
        end
      end
      MARK: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (half_reg == half_last) begin
          half_next = '0;
          if (ir_reg) begin
            ir_next = 1'b0;
          end else if (period_reg == 9'd1) begin
            // low half of the final period just ended
            if (rep_reg) begin
              state_next = GAP;
              gap_next   = '0;
            end else begin
              go_idle = 1'b1;
            end
          end else begin
            period_next = period_reg - 9'd1;
            ir_next     = 1'b1;
          end
        end else begin
          half_next = half_reg + 17'd1;
        end
      end
      GAP: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (gap_reg == GAP_LAST) begin
          state_next  = MARK;
          ir_next     = 1'b1;
          half_next   = '0;
          period_next = load_len(len_reg);
        end else begin
          gap_next = gap_reg + 24'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (go_idle) begin
      state_next  = IDLE;
      ir_next     = 1'b0;
      done_next   = 1'b1;
      sel_next    = 2'b00;
      half_next   = '0;
      period_next = '0;
      gap_next    = '0;
    end
  end

  assign ir_out  = ir_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign cur_sel = sel_reg;

endmodule

// File: tb/tb_beacon_tx.sv
// Directed bench for beacon_tx: per-cycle expected outputs go through a
// scoreboard queue and are checked 1 time unit after each rising edge.
module tb_beacon_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [7:0] burst_len = 8'd0;
  logic       repeat_en = 1'b0;
  logic       stop = 1'b0;
  logic       ir_out, busy, done;
  logic [1:0] cur_sel;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       ir;
    logic       bsy;
    logic       dn;
    logic [1:0] cs;
  } exp_t;

  exp_t sb[$];

  beacon_tx #(.HALF1(4), .HALF2(3), .HALF3(2), .GAP_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .burst_len(burst_len),
    .repeat_en(repeat_en), .stop(stop), .ir_out(ir_out), .busy(busy),
    .done(done), .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;

  task automatic sample(input string tag);
    exp_t e;
    exp_t got;
    e = sb.pop_front();
    got = {ir_out, busy, done, cur_sel};
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL %s: got ir=%b busy=%b done=%b cur_sel=%b, want ir=%b busy=%b done=%b cur_sel=%b",
             tag, got.ir, got.bsy, got.dn, got.cs, e.ir, e.bsy, e.dn, e.cs);
    end
  endtask

  task automatic chk(input string tag, input logic ir, input logic b, input logic d,
                     input logic [1:0] cs);
    exp_t e;
    e = {ir, b, d, cs};
    sb.push_back(e);
    @(posedge clk);
    #1;
    sample(tag);
  endtask

  // t counts cycles after the accepting edge; high for the first half of each period
  task automatic carrier(input string tag, input int half, input logic [1:0] cs,
                         input int t0, input int t1);
    for (int t = t0; t <= t1; t++) begin
      chk(tag, ((t / half) % 2) == 0, 1'b1, 1'b0, cs);
    end
  endtask

  task automatic start_burst(input string tag, input logic [1:0] s, input logic [7:0] len,
                             input logic rep);
    sel = s;
    burst_len = len;
    repeat_en = rep;
    start = 1'b1;
    chk(tag, 1'b1, 1'b1, 1'b0, s);
    start = 1'b0;
  endtask

  task automatic end_idle(input string tag);
    chk(tag, 1'b0, 1'b0, 1'b1, 2'b00);
    chk(tag, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    // reset state
    #1;
    sb.push_back(exp_t'(5'b0));
    sample("reset_async");
    @(posedge clk);
    #1;
    chk("reset_held", 1'b0, 1'b0, 1'b0, 2'b00);
    rst_n = 1'b1;
    chk("reset_release", 1'b0, 1'b0, 1'b0, 2'b00);
    $display("txn reset: outputs idle");

    // single burst, carrier 1, 3 periods -> done 24 cycles after start
    start_burst("single_start", 2'b01, 8'd3, 1'b0);
    carrier("single_carrier", 4, 2'b01, 1, 23);
    end_idle("single_done");
    $display("txn single burst sel=01 len=3");

    start_burst("c2_start", 2'b10, 8'd2, 1'b0);
    carrier("c2_carrier", 3, 2'b10, 1, 11);
    end_idle("c2_done");
    $display("txn carrier 2 sel=10 len=2");

    start_burst("c3_start", 2'b11, 8'd2, 1'b0);
    carrier("c3_carrier", 2, 2'b11, 1, 7);
    end_idle("c3_done");
    $display("txn carrier 3 sel=11 len=2");

    // repeat mode; inputs change while busy and must be ignored
    start_burst("rep_start", 2'b11, 8'd2, 1'b1);
    sel = 2'b01;
    burst_len = 8'd5;
    repeat_en = 1'b0;
    carrier("rep_burst1", 2, 2'b11, 1, 7);
    for (int i = 0; i < 10; i++) chk("rep_gap1", 1'b0, 1'b1, 1'b0, 2'b11);
    chk("rep_burst2_rise", 1'b1, 1'b1, 1'b0, 2'b11);
    carrier("rep_burst2", 2, 2'b11, 1, 7);
    for (int i = 0; i < 4; i++) chk("rep_gap2", 1'b0, 1'b1, 1'b0, 2'b11);
    stop = 1'b1;
    chk("rep_stop_done", 1'b0, 1'b0, 1'b1, 2'b00);
    stop = 1'b0;
    for (int i = 0; i < 3; i++) chk("rep_after_stop", 1'b0, 1'b0, 1'b0, 2'b00);
    $display("txn repeat sel=11 len=2, stopped in second gap");

    // burst_len=0 -> 256 periods (1024 cycles)
    start_burst("len256_start", 2'b11, 8'd0, 1'b0);
    carrier("len256_carrier", 2, 2'b11, 1, 1023);
    end_idle("len256_done");
    $display("txn burst_len=0 -> 256 periods");

    sel = 2'b00;
    burst_len = 8'd3;
    start = 1'b1;
    chk("sel00_ignored", 1'b0, 1'b0, 1'b0, 2'b00);
    start = 1'b0;
    chk("sel00_idle", 1'b0, 1'b0, 1'b0, 2'b00);
    $display("txn start with sel=00 ignored");

    sel = 2'b01;
    start = 1'b1;
    stop = 1'b1;
    chk("start_stop_idle", 1'b0, 1'b0, 1'b0, 2'b00);
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_after", 1'b0, 1'b0, 1'b0, 2'b00);
    $display("txn start+stop in idle ignored");

    // start while busy leaves the burst untouched
    start_burst("busy_start", 2'b01, 8'd2, 1'b0);
    carrier("busy_carrier", 4, 2'b01, 1, 4);
    start = 1'b1;
    sel = 2'b10;
    burst_len = 8'd1;
    carrier("busy_restart", 4, 2'b01, 5, 5);
    start = 1'b0;
    carrier("busy_carrier", 4, 2'b01, 6, 15);
    end_idle("busy_done");
    $display("txn start while busy ignored");

    start_burst("stop_start", 2'b01, 8'd3, 1'b0);
    carrier("stop_carrier", 4, 2'b01, 1, 1);
    stop = 1'b1;
    chk("stop_high_done", 1'b0, 1'b0, 1'b1, 2'b00);
    stop = 1'b0;
    chk("stop_high_after", 1'b0, 1'b0, 1'b0, 2'b00);
    $display("txn stop mid-high-half");

    // async reset mid-burst, checked between clock edges
    start_burst("arst_start", 2'b10, 8'd4, 1'b0);
    carrier("arst_carrier", 3, 2'b10, 1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(exp_t'(5'b0));
    sample("arst_immediate");
    chk("arst_held", 1'b0, 1'b0, 1'b0, 2'b00);
    rst_n = 1'b1;
    chk("arst_release", 1'b0, 1'b0, 1'b0, 2'b00);
    start_burst("arst_restart", 2'b11, 8'd1, 1'b0);
    carrier("arst_carrier2", 2, 2'b11, 1, 3);
    end_idle("arst_done");
    $display("txn async reset mid-burst then restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/beacon_tx.md
# beacon_tx

Modulated IR beacon transmitter for the rover's photodiode-based frequency detection. The block drives an IR LED with a square-wave carrier at one of three selectable frequencies, sent in bursts separated by silent gaps. A frequency classifier on the receiving rover maps each carrier to a 2-bit frequency code; this block generates those same three carriers. It sits on the beacon/base-station board and is controlled by switches or a host FSM through a start/stop interface.

## Interface
- HALF1, 50000, half-period of carrier 1 in clock cycles (1 kHz at 100 MHz)
- HALF2, 25000, half-period of carrier 2 in clock cycles (2 kHz)
- HALF3, 16667, half-period of carrier 3 in clock cycles (~3 kHz)
- GAP_CYC, 10000000, silent gap between repeated bursts in clock cycles (100 ms)
- clock  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  request to begin transmission, sampled on rising edge of clock
- sel  in  2  carrier select: 01 = HALF1, 10 = HALF2, 11 = HALF3, 00 = none
- burst_len  in  8  carrier periods per burst; 0 means 256
- repeat  in  1  1 = repeat bursts with gaps until stop; 0 = single burst
- stop  in  1  abort the transmission in progress
- ir_out  out  1  LED drive
- busy  out  1  high from the accepted start until return to IDLE
- done  out  1  one-cycle pulse on return to IDLE
- cur_sel  out  2  latched select of the active transmission; 00 when idle

## Operation
- Reset values: ir_out=0, busy=0, done=0, cur_sel=00, FSM=IDLE, all counters 0.
- States: IDLE, MARK (carrier toggling), GAP (ir_out held 0).
- IDLE: if start=1, stop=0 and sel≠00, latch sel, burst_len and repeat. On the same edge, go to MARK with ir_out=1 and busy=1. If sel=00, start is ignored.
- MARK: the half-period counter counts 0..HALFn−1. At HALFn−1, ir_out toggles and the counter returns to 0.
  - Each high→low→high completion, i.e. the end of a low half, counts one period.
  - At the end of the low half of the last period:
    - If the latched repeat=1, go to GAP.
    - Otherwise go to IDLE: busy=0, cur_sel=00, done=1 for one cycle.
- GAP: count GAP_CYC cycles with ir_out=0. Then go to MARK with ir_out=1, reloading the period count from the latched burst_len.
- The latched sel, burst_len and repeat are not affected by input changes while busy=1.
- stop=1 while busy: on the next edge go to IDLE with ir_out=0, busy=0 and done=1. A partial period is truncated.
- start while busy is ignored. In IDLE, start and stop asserted together results in stop winning, and nothing starts.
- Counters: half-period counter is 17 bits; period counter is 9 bits (holds 1..256); gap counter is 24 bits. No counter wraps in normal operation.

## Timing
- Start sampled at edge k: ir_out=1, busy=1 and cur_sel valid from edge k.
- Carrier period is exactly 2·HALFn cycles at 50% duty.
- A single burst of N periods occupies 2·N·HALFn cycles from edge k. The done pulse coincides with the final ir_out high→low? No: ir_out goes low at edge k+(2N−1)·HALFn, and done/busy=0 follow at edge k+2N·HALFn.
- Repeat mode: the next burst's ir_out rises GAP_CYC cycles after the previous burst's last period ends.
- Stop sampled at edge s: ir_out=0 and busy=0 from edge s, with done high for the cycle after edge s.
- A new start is accepted in the cycle after done (when busy=0).
- Reset deasserting mid-operation: the block resumes in IDLE. Asserting reset zeroes outputs without waiting for a clock.

## Test plan
Bench parameters: HALF1=4, HALF2=3, HALF3=2, GAP_CYC=10.
- Single burst: sel=01, burst_len=3, repeat=0, start pulse → ir_out gives 3 periods of 4 high / 4 low cycles; done pulse 24 cycles after start; busy high for 24 cycles.
- Each carrier: sel=10 then sel=11, burst_len=2 → half-periods of 3 and 2 cycles respectively; cur_sel equals sel while busy.
- Repeat mode: sel=11, burst_len=2, repeat=1 → 8 cycles of carrier, 10 cycles low, 8 cycles of carrier, repeating; stop during the second gap → done next cycle and ir_out stays 0.
- Boundaries:
  - burst_len=0 with sel=11 → 256 periods (1024 cycles).
  - start with sel=00 → no response.
  - start and stop together in IDLE → no response.
  - start while busy → ignored, and the burst count is unchanged.
- Stop mid-high-half and async reset mid-burst:
  - On stop, ir_out falls on the next edge and done pulses once.
  - On reset low, ir_out, busy and cur_sel go to 0 without a clock edge.
  - After release, a new start works normally.
